// File: rtl/dsp48a1_op_sequencer.sv
// Command-driven sequencer for one DSP48A1 slice: issues one opcode, holds operands for LATENCY cycles, pulses CEP once, returns P.
// Optional DSP_SEQ_OPCNT_EN adds a saturating 16-bit response counter on port op_count.
module dsp48a1_op_sequencer #(
   parameter int LATENCY = 4
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [17:0] cmd_a,
   input  logic [17:0] cmd_b,
   input  logic [47:0] cmd_c,
   input  logic [17:0] cmd_d,
   input  logic        cmd_cin,
   output logic [17:0] dsp_A,
   output logic [17:0] dsp_B,
   output logic [47:0] dsp_C,
   output logic [17:0] dsp_D,
   output logic        dsp_CARRYIN,
   output logic [7:0]  dsp_OPMODE,
   output logic        dsp_CE,
   output logic        dsp_CEP,
   output logic        dsp_RST,
   output logic        dsp_RSTP,
   input  logic [47:0] dsp_P,
   input  logic        dsp_CARRYOUT,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [47:0] rsp_p,
   output logic        rsp_carry
`ifdef DSP_SEQ_OPCNT_EN
   ,
   output logic [15:0] op_count
`endif
);

   localparam logic [3:0] LAT = 4'(LATENCY);

   typedef enum logic [2:0] {IDLE, ISSUE, CLR, CAPT, DONE} state_t;

   state_t     state;
   logic [3:0] cnt;

   function automatic logic [7:0] opmode_of(input logic [2:0] op, input logic cin);
      logic [7:0] m;
      case (op)
         3'd0:    m = 8'b0000_0001;
         3'd1:    m = 8'b0000_1101;
         3'd2:    m = 8'b1000_1101;
         3'd3:    m = 8'b0001_0001;
         3'd4:    m = 8'b0101_0001;
         3'd5:    m = 8'b0000_1001;
         3'd7:    m = 8'b1101_1101;
         default: m = 8'b0000_0000;
      endcase
      m[5] = cin;
      return m;
   endfunction

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state       <= IDLE;
         cnt         <= '0;
         dsp_A       <= '0;
         dsp_B       <= '0;
         dsp_C       <= '0;
         dsp_D       <= '0;
         dsp_CARRYIN <= 1'b0;
         dsp_OPMODE  <= '0;
         dsp_CE      <= 1'b0;
         dsp_CEP     <= 1'b0;
         dsp_RST     <= 1'b1;
         dsp_RSTP    <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_p       <= '0;
         rsp_carry   <= 1'b0;
         cmd_ready   <= 1'b0;
      end else begin
         dsp_RST  <= 1'b0;
         dsp_RSTP <= 1'b0;
         case (state)
            IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready   <= 1'b0;
                  dsp_A       <= cmd_a;
                  dsp_B       <= cmd_b;
                  dsp_C       <= cmd_c;
                  dsp_D       <= cmd_d;
                  dsp_CARRYIN <= cmd_cin;
                  if (cmd_op == 3'd6) begin
                     // CLEAR leaves OPMODE alone and zeroes P via the synchronous RSTP
                     dsp_RSTP <= 1'b1;
                     state    <= CLR;
                  end else begin
                     dsp_OPMODE <= opmode_of(cmd_op, cmd_cin);
                     dsp_CE     <= 1'b1;
                     dsp_CEP    <= (LAT == 4'd1);
                     cnt        <= 4'd1;
                     state      <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (cnt == LAT) begin
                  dsp_CE  <= 1'b0;
                  dsp_CEP <= 1'b0;
                  cnt     <= '0;
                  state   <= CAPT;
               end else begin
                  cnt     <= cnt + 4'd1;
                  dsp_CEP <= ((cnt + 4'd1) == LAT);
               end
            end
            CLR: state <= CAPT;
            CAPT: begin
               rsp_p     <= dsp_P;
               rsp_carry <= dsp_CARRYOUT;
               rsp_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DSP_SEQ_OPCNT_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         op_count <= '0;
      else if (rsp_valid && rsp_ready)
         op_count <= sat_inc(op_count);
   end
`endif

endmodule

// File: tb/tb_dsp48a1_op_sequencer.sv
// Bench for dsp48a1_op_sequencer: a behavioural DSP48A1 slice plus a spec-level result model; checks directed and random ops.
// Build with DSP_SEQ_OPCNT_EN defined to also check op_count.
module tb_dsp48a1_op_sequencer;

   localparam int LAT = 4;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        cmd_valid, cmd_ready, cmd_cin;
   logic [2:0]  cmd_op;
   logic [17:0] cmd_a, cmd_b, cmd_d;
   logic [47:0] cmd_c;
   logic [17:0] dsp_A, dsp_B, dsp_D;
   logic [47:0] dsp_C, dsp_P;
   logic        dsp_CARRYIN, dsp_CE, dsp_CEP, dsp_RST, dsp_RSTP, dsp_CARRYOUT;
   logic [7:0]  dsp_OPMODE;
   logic        rsp_valid, rsp_ready, rsp_carry;
   logic [47:0] rsp_p;
`ifdef DSP_SEQ_OPCNT_EN
   logic [15:0] op_count;
`endif

   int          passes = 0;
   int          total  = 0;
   int          hs_cnt = 0;
   int          exp_lat, exp_cep;
   logic [47:0] exp_p, acc, got_p, held_p;
   logic        exp_cin;

   dsp48a1_op_sequencer #(.LATENCY(LAT)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_d(cmd_d), .cmd_cin(cmd_cin),
      .dsp_A(dsp_A), .dsp_B(dsp_B), .dsp_C(dsp_C), .dsp_D(dsp_D),
      .dsp_CARRYIN(dsp_CARRYIN), .dsp_OPMODE(dsp_OPMODE),
      .dsp_CE(dsp_CE), .dsp_CEP(dsp_CEP), .dsp_RST(dsp_RST), .dsp_RSTP(dsp_RSTP),
      .dsp_P(dsp_P), .dsp_CARRYOUT(dsp_CARRYOUT),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p), .rsp_carry(rsp_carry)
`ifdef DSP_SEQ_OPCNT_EN
      , .op_count(op_count)
`endif
   );

   always #5 CLK = ~CLK;

   // Slice model: decodes OPMODE like a DSP48A1 and updates P only on CEP
   function automatic logic [48:0] slice_calc(input logic [17:0] a, input logic [17:0] b,
                                              input logic [47:0] c, input logic [17:0] d,
                                              input logic [47:0] p, input logic [7:0] om);
      logic signed [17:0] bp;
      logic signed [35:0] m;
      logic [47:0] x, z;
      if (!om[4])     bp = $signed(b);
      else if (om[6]) bp = $signed(d) - $signed(b);
      else            bp = $signed(d) + $signed(b);
      m = $signed(a) * bp;
      x = (om[1:0] == 2'b01) ? {{12{m[35]}}, m} : 48'd0;
      case (om[3:2])
         2'b10:   z = p;
         2'b11:   z = c;
         default: z = '0;
      endcase
      if (om[7]) return {1'b0, z} - ({1'b0, x} + {48'd0, om[5]});
      return {1'b0, z} + {1'b0, x} + {48'd0, om[5]};
   endfunction

   logic [47:0] slice_p  = '0;
   logic        slice_co = 1'b0;
   always @(posedge CLK) begin
      if (dsp_RSTP) begin
         slice_p  <= '0;
         slice_co <= 1'b0;
      end else if (dsp_CEP) begin
         {slice_co, slice_p} <= slice_calc(dsp_A, dsp_B, dsp_C, dsp_D, slice_p, dsp_OPMODE);
      end
   end
   assign dsp_P        = slice_p;
   assign dsp_CARRYOUT = slice_co;

   // Result the opcode should produce, from plain signed arithmetic
   function automatic logic [47:0] ref_op(input logic [2:0] op, input logic [17:0] a,
                                          input logic [17:0] b, input logic [47:0] c,
                                          input logic [17:0] d, input logic cin,
                                          input logic [47:0] prev);
      longint sa, sb, sd, sc, sp, ci, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sd = longint'($signed(d));
      sc = longint'(c);
      sp = longint'(prev);
      ci = longint'(cin);
      case (op)
         3'd0:    r = sa * sb + ci;
         3'd1:    r = sc + sa * sb + ci;
         3'd2:    r = sc - (sa * sb + ci);
         3'd3:    r = (sd + sb) * sa + ci;
         3'd4:    r = (sd - sb) * sa + ci;
         3'd5:    r = sp + sa * sb + ci;
         3'd6:    r = 0;
         default: r = sc - ((sd - sb) * sa + ci);
      endcase
      return r[47:0];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic present(input logic [2:0] op, input logic [17:0] a, input logic [17:0] b,
                          input logic [47:0] c, input logic [17:0] d, input logic cin);
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_c = c; cmd_d = d; cmd_cin = cin;
      cmd_valid = 1'b1;
      exp_p   = ref_op(op, a, b, c, d, cin, acc);
      acc     = exp_p;
      exp_cin = cin;
      exp_lat = (op == 3'd6) ? 2 : LAT + 1;
      exp_cep = (op == 3'd6) ? 0 : 1;
   endtask

   task automatic wait_accept(input string tag);
      int n = 0;
      while (!cmd_ready && n < 100) begin
         @(posedge CLK); #1;
         n++;
      end
      chk({tag, " ready"}, cmd_ready, 1'b1);
      @(posedge CLK); #1;
      cmd_valid = 1'b0;
      chk({tag, " carryin"}, dsp_CARRYIN, exp_cin);
   endtask

   task automatic wait_rsp(input string tag);
      int lat = 0;
      int cep = 0;
      while (!rsp_valid && lat < 40) begin
         @(posedge CLK); #1;
         lat++;
         if (dsp_CEP) cep++;
      end
      got_p = rsp_p;
      chk({tag, " latency"}, lat, exp_lat);
      chk({tag, " cep pulses"}, cep, exp_cep);
      chk({tag, " p"}, rsp_p, exp_p);
      chk({tag, " carry"}, rsp_carry, slice_co);
   endtask

   task automatic handshake(input string tag);
      rsp_ready = 1'b1;
      @(posedge CLK); #1;
      rsp_ready = 1'b0;
      chk({tag, " valid drop"}, rsp_valid, 1'b0);
      chk({tag, " ready back"}, cmd_ready, 1'b1);
`ifdef DSP_SEQ_OPCNT_EN
      hs_cnt++;
      chk({tag, " op_count"}, op_count, hs_cnt);
`endif
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [17:0] a,
                         input logic [17:0] b, input logic [47:0] c, input logic [17:0] d,
                         input logic cin);
      present(op, a, b, c, d, cin);
      wait_accept(tag);
      wait_rsp(tag);
      handshake(tag);
   endtask

   initial begin
      logic [31:0] r1, r2, r3, r4;
      RST_N = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
      cmd_c = '0; cmd_d = '0; cmd_cin = 1'b0; rsp_ready = 1'b0; acc = '0;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst rsp_valid", rsp_valid, 1'b0);
      chk("rst cmd_ready", cmd_ready, 1'b0);
      chk("rst dsp_RST", dsp_RST, 1'b1);
      chk("rst dsp_RSTP", dsp_RSTP, 1'b1);
      chk("rst dsp_CE", dsp_CE, 1'b0);
      chk("rst dsp_CEP", dsp_CEP, 1'b0);
      chk("rst opmode", dsp_OPMODE, 8'h00);
      chk("rst rsp_p", rsp_p, 48'h0);
      #2 RST_N = 1'b1;
      @(posedge CLK); #1;
      chk("rel dsp_RST", dsp_RST, 1'b0);
      chk("rel dsp_RSTP", dsp_RSTP, 1'b0);
      chk("rel cmd_ready", cmd_ready, 1'b1);

      present(3'd0, 18'd3, 18'd4, 48'd0, 18'd0, 1'b0);
      wait_accept("abort");
      @(posedge CLK); #1;
      chk("abort in issue", dsp_CE, 1'b1);
      RST_N = 1'b0;
      #1;
      chk("abort rsp_valid", rsp_valid, 1'b0);
      chk("abort dsp_RST", dsp_RST, 1'b1);
      chk("abort dsp_RSTP", dsp_RSTP, 1'b1);
      chk("abort dsp_CE", dsp_CE, 1'b0);
      chk("abort cmd_ready", cmd_ready, 1'b0);
      acc = '0;
      hs_cnt = 0;
      @(posedge CLK);
      @(posedge CLK);
      #2 RST_N = 1'b1;
      @(posedge CLK); #1;
      chk("abort rel dsp_RST", dsp_RST, 1'b0);
      chk("abort rel dsp_RSTP", dsp_RSTP, 1'b0);
      chk("abort rel cmd_ready", cmd_ready, 1'b1);

      run_op("mul", 3'd0, 18'd3, 18'd4, 48'd0, 18'd0, 1'b0);
      chk("mul literal", got_p, 48'hC);
      run_op("presub_msub", 3'd7, 18'd20, 18'd10, 48'd350, 18'd25, 1'b0);
      chk("presub_msub literal", got_p, 48'h32);
      chk("presub_msub carry literal", rsp_carry, 1'b0);
      run_op("preadd", 3'd3, 18'd20, 18'd10, 48'd0, 18'd25, 1'b0);
      chk("preadd literal", got_p, 48'h2BC);
      run_op("presub", 3'd4, 18'd20, 18'd10, 48'd0, 18'd25, 1'b0);
      chk("presub literal", got_p, 48'h12C);
      run_op("clear", 3'd6, 18'd0, 18'd0, 48'd0, 18'd0, 1'b0);
      chk("clear literal", got_p, 48'h0);
      run_op("accum1", 3'd5, 18'd5, 18'd6, 48'd0, 18'd0, 1'b0);
      chk("accum1 literal", got_p, 48'h1E);
      run_op("accum2", 3'd5, 18'd5, 18'd6, 48'd0, 18'd0, 1'b0);
      chk("accum2 literal", got_p, 48'h3C);
      run_op("msub", 3'd2, 18'd5, 18'd6, 48'd0, 18'd0, 1'b0);
      chk("msub literal", got_p, 48'hFFFF_FFFF_FFE2);

      present(3'd0, 18'd7, 18'd8, 48'd0, 18'd0, 1'b0);
      wait_accept("bp first");
      wait_rsp("bp first");
      held_p = rsp_p;
      present(3'd1, 18'd2, 18'd9, 48'd100, 18'd0, 1'b1);
      repeat (3) begin
         @(posedge CLK); #1;
         chk("bp rsp_p stable", rsp_p, held_p);
         chk("bp rsp_valid held", rsp_valid, 1'b1);
         chk("bp cmd_ready low", cmd_ready, 1'b0);
         chk("bp not issued", dsp_CE, 1'b0);
      end
      handshake("bp first");
      @(posedge CLK); #1;
      cmd_valid = 1'b0;
      chk("bp accepted", dsp_CE, 1'b1);
      chk("bp ready low", cmd_ready, 1'b0);
      wait_rsp("bp second");
      handshake("bp second");

      for (int i = 0; i < 20; i++) begin
         r1 = $urandom; r2 = $urandom; r3 = $urandom; r4 = $urandom;
         run_op("rand", r1[2:0], r1[20:3], {{2{r2[15]}}, r2[15:0]}, {r3[15:0], r4},
                {{2{r2[31]}}, r2[31:16]}, r1[21]);
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

// File: doc/dsp48a1_op_sequencer.md
Name: dsp48a1_op_sequencer

Overview:
- Command-driven initiator that drives a DSP48A1 slice's data, OPMODE, clock-enable and reset ports, then returns the P result.
- Accepts one operation per valid/ready handshake and maps an opcode to OPMODE.
- Holds operands stable for the slice's pipeline depth, pulses the P-register enable exactly once, captures P/CARRYOUT and presents a response.
- Sits between a control/microcode block and the DSP48A1 instance.

Parameters:
- LATENCY, 4, cycles operands and CE are held before the P update. Must equal the slice's input-to-M register depth +1. Legal range 2..15.

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer idle, can accept
- cmd_op  in  3  opcode
- cmd_a  in  18  operand A
- cmd_b  in  18  operand B
- cmd_c  in  48  operand C
- cmd_d  in  18  operand D
- cmd_cin  in  1  carry-in
- dsp_A  out  18  to slice A
- dsp_B  out  18  to slice B
- dsp_C  out  48  to slice C
- dsp_D  out  18  to slice D
- dsp_CARRYIN  out  1  to slice CARRYIN
- dsp_OPMODE  out  8  to slice OPMODE
- dsp_CE  out  1  drives CEA/CEB/CEC/CED/CEM/CEOPMODE/CECARRYIN
- dsp_CEP  out  1  drives CEP
- dsp_RST  out  1  drives all slice RST* except RSTP
- dsp_RSTP  out  1  drives RSTP
- dsp_P  in  48  slice P
- dsp_CARRYOUT  in  1  slice CARRYOUT
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_p  out  48  captured P
- rsp_carry  out  1  captured CARRYOUT

Behaviour:
- Reset (RST_N low, async):
  - State IDLE; counter 0.
  - All dsp_* data/OPMODE outputs 0; dsp_CE=0, dsp_CEP=0.
  - dsp_RST=1, dsp_RSTP=1.
  - rsp_valid=0, rsp_p=0, rsp_carry=0; cmd_ready=0 while reset is asserted.
- First edge after release: dsp_RST and dsp_RSTP drop to 0; cmd_ready=1.
- Opcode map (dsp_OPMODE, result):
  - 0 MUL: 00000001, P=A*B
  - 1 MACC: 00001101, P=C+A*B
  - 2 MSUB: 10001101, P=C-A*B
  - 3 PREADD: 00010001, P=(D+B)*A
  - 4 PRESUB: 01010001, P=(D-B)*A
  - 5 ACCUM: 00001001, P=P+A*B
  - 6 CLEAR: no OPMODE change, P=0
  - 7 PRESUB_MSUB: 11011101, P=C-(D-B)*A
  - OPMODE bit5 = cmd_cin for all opcodes.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch operands and OPMODE into the dsp_* drive registers.
  - Opcode 6 goes to CLR; all others go to ISSUE with counter=1.
- ISSUE:
  - dsp_CE=1; the dsp_* drives are held constant.
  - Counter increments each cycle.
  - dsp_CEP=1 only in the cycle where counter==LATENCY, then go to CAPT. P updates exactly once per op, which keeps ACCUM correct.
- CLR: dsp_RSTP=1 for one cycle, then go to CAPT.
- CAPT: one cycle. On its closing edge, rsp_p<=dsp_P, rsp_carry<=dsp_CARRYOUT, rsp_valid<=1; go to DONE.
- DONE:
  - rsp_valid held with stable rsp_p/rsp_carry until rsp_valid&rsp_ready, then return to IDLE and rsp_valid=0.
  - cmd_ready=0; commands are not accepted.
- Outside ISSUE: dsp_CE=0 and dsp_CEP=0, so the slice retains P between ops.
- Response latency:
  - Compute ops: rsp_valid rises LATENCY+1 rising edges after the accepting edge (5 at default).
  - CLEAR: rsp_valid rises 2 rising edges after the accepting edge.
- Throughput: one op in flight. cmd_ready rises the cycle after the response handshake.
- No wrap: the counter only spans 1..LATENCY.
- Async reset mid-ISSUE/CAPT/DONE: abort the op, drop rsp_valid immediately, and apply the reset values above. The slice is reset through dsp_RST/dsp_RSTP.

Optional Feature:
- Macro: DSP_SEQ_OPCNT_EN.
- Defined:
  - Adds output op_count[15:0], reset 0.
  - Increments on each response handshake and saturates at 16'hFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: assert RST_N low mid-ISSUE of a MUL -> rsp_valid=0 immediately and dsp_RST=dsp_RSTP=1. One edge after release: dsp_RST=dsp_RSTP=0 and cmd_ready=1. A subsequent MUL A=3,B=4 returns 0xC.
- op7 with A=20, B=10, C=350, D=25, cin=0 -> rsp_p=0x32, rsp_carry=0; rsp_valid rises exactly 5 edges after accept; dsp_CEP high for exactly one cycle.
- op3 with A=20, B=10, D=25 -> rsp_p=0x2BC; op4 with the same operands -> 0x12C.
- CLEAR, then ACCUM A=5,B=6 twice -> 0x0, then 0x1E, then 0x3C. Confirms a single P update per op.
- op2 with A=5, B=6, C=0 -> rsp_p=0xFFFFFFFFFFE2. rsp_carry equals the slice CARRYOUT sampled in CAPT.
- Backpressure: rsp_ready=0 for 3 cycles with cmd_valid=1 and a new op present -> rsp_p stable, cmd_ready=0, new op not accepted. It is accepted the cycle after the handshake. With DSP_SEQ_OPCNT_EN defined, op_count increments by 1 per handshake.
